// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: address bus, resolver FSM states, queue entry and mispredict compare.
// The mispredict compare is also used by fetch so both sides agree on what a redirect means.
package branch_resolver_pkg;

    localparam int ADDR_BUS = 32;

    typedef logic [ADDR_BUS-1:0] addr_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rslv_state_t;

    typedef struct packed {
        addr_t pc;
        addr_t target;       // static target until resolved, actual target afterwards
        addr_t pred_target;
        logic  pred_taken;
        logic  is_jump;
        logic  taken;
        logic  resolved;
    } br_entry_t;

    function automatic logic br_mispredict(logic taken, addr_t target,
                                           logic pred_taken, addr_t pred_target);
        return (taken != pred_taken) || (taken && (target != pred_target));
    endfunction

    // Jumps (JR/JALR) take their target from execute; conditionals keep the static target.
    function automatic br_entry_t br_apply_res(br_entry_t e, logic res_taken, addr_t res_target);
        br_entry_t r;
        r          = e;
        r.resolved = 1'b1;
        if (e.is_jump) begin
            r.taken  = 1'b1;
            r.target = res_target;
        end else begin
            r.taken = res_taken;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// ID / execute-broadcast / fetch-side bus of the branch resolver.
// master drives ID and resolution inputs; slave is the resolver.
interface branch_resolver_if #(
    parameter int TAG_W = 4
) ();
    import branch_resolver_pkg::*;

    logic             id_valid;
    logic             id_ready;
    addr_t            id_pc;
    logic             id_is_jump;
    logic             id_is_taken;
    logic             id_is_determined;
    addr_t            id_target;
    logic [TAG_W-1:0] id_tag;
    logic             id_pred_taken;
    addr_t            id_pred_target;

    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic             res_taken;
    addr_t            res_target;

    logic             redirect_valid;
    addr_t            redirect_pc;
    logic             upd_valid;
    addr_t            upd_pc;
    logic             upd_taken;
    addr_t            upd_target;

    modport master (
        output id_valid, id_pc, id_is_jump, id_is_taken, id_is_determined, id_target,
               id_tag, id_pred_taken, id_pred_target,
               res_valid, res_tag, res_taken, res_target,
        input  id_ready, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target
    );

    modport slave (
        input  id_valid, id_pc, id_is_jump, id_is_taken, id_is_determined, id_target,
               id_tag, id_pred_taken, id_pred_target,
               res_valid, res_tag, res_taken, res_target,
        output id_ready, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target
    );

endinterface

// File: rtl/branch_pending_queue.sv
// In-order pending branch queue with a tag CAM for out-of-order resolution.
// Latency: enqueue/resolve visible next cycle; head view bypasses a same-cycle resolution.
// Backpressure: full flag only; caller must not enqueue when full.
module branch_pending_queue
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             enq,
    input  br_entry_t        enq_entry,
    input  logic [TAG_W-1:0] enq_tag,
    input  logic             pop,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    input  addr_t            res_target,
    output logic             empty,
    output logic             full,
    output br_entry_t        head
);

    localparam int PW = $clog2(DEPTH);

    br_entry_t        mem  [DEPTH];
    logic [TAG_W-1:0] tags [DEPTH];
    logic [PW-1:0]    hd;
    logic [PW-1:0]    tl;
    logic [PW:0]      cnt;
    logic [DEPTH-1:0] hit;
    logic             enq_hit;

    assign empty = (cnt == '0);
    assign full  = (cnt == (PW+1)'(DEPTH));

    // A slot is live when its distance from head is below the occupancy count.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = ({1'b0, PW'(PW'(i) - hd)} < cnt) && !mem[i].resolved &&
                     res_valid && (tags[i] == res_tag);
        end
    end

    assign enq_hit = res_valid && !enq_entry.resolved && (enq_tag == res_tag);

    always_comb begin
        head = mem[hd];
        if (hit[hd]) head = br_apply_res(mem[hd], res_taken, res_target);
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit[i]) mem[i] <= br_apply_res(mem[i], res_taken, res_target);
            end
            if (enq) begin
                mem[tl]  <= enq_hit ? br_apply_res(enq_entry, res_taken, res_target) : enq_entry;
                tags[tl] <= enq_tag;
                tl       <= tl + PW'(1);
            end
            if (pop) hd <= hd + PW'(1);
            cnt <= cnt + {{PW{1'b0}}, enq} - {{PW{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves ID branches in program order; redirect + predictor update pulses (perf counters under BRANCH_RESOLVER_PERF_EN).
// Latency: outcome known in cycle N (direct or head retire) -> redirect/upd registered in N+1.
// Backpressure: id_ready low when the queue is full or for one FLUSH cycle after a redirect.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush_in,
    branch_resolver_if.slave bus
`ifdef BRANCH_RESOLVER_PERF_EN
    ,
    output logic [31:0] perf_branch_cnt,
    output logic [31:0] perf_mispred_cnt
`endif
);

    rslv_state_t state;
    br_entry_t   id_entry;
    br_entry_t   head;
    br_entry_t   fin;
    logic        q_empty;
    logic        q_full;
    logic        accept;
    logic        direct;
    logic        retire;
    logic        finish;
    logic        mispred;
    logic        enq;
    logic        pop;
    logic        q_clr;

    always_comb begin
        id_entry             = '0;
        id_entry.pc          = bus.id_pc;
        id_entry.target      = bus.id_target;
        id_entry.pred_target = bus.id_pred_target;
        id_entry.pred_taken  = bus.id_pred_taken;
        id_entry.is_jump     = bus.id_is_jump;
        id_entry.taken       = bus.id_is_determined && bus.id_is_taken;
        id_entry.resolved    = bus.id_is_determined;
    end

    assign bus.id_ready = (state == RUN) && !q_full;
    assign accept       = bus.id_valid && bus.id_ready;

    // Head retire wins; a direct resolve only happens with an empty queue, so they never collide.
    assign retire  = !q_empty && head.resolved;
    assign direct  = accept && q_empty && bus.id_is_determined;
    assign finish  = retire || direct;
    assign fin     = retire ? head : id_entry;
    assign mispred = finish && br_mispredict(fin.taken, fin.target, fin.pred_taken, fin.pred_target);
    assign enq     = accept && !direct && !mispred;
    assign pop     = retire && !mispred;
    assign q_clr   = flush_in || mispred;

    branch_pending_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .clr        (q_clr),
        .enq        (enq),
        .enq_entry  (id_entry),
        .enq_tag    (bus.id_tag),
        .pop        (pop),
        .res_valid  (bus.res_valid),
        .res_tag    (bus.res_tag),
        .res_taken  (bus.res_taken),
        .res_target (bus.res_target),
        .empty      (q_empty),
        .full       (q_full),
        .head       (head)
    );

    always_ff @(posedge clk) begin
        if (!rst || flush_in) begin
            state              <= RUN;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.upd_valid      <= 1'b0;
            bus.upd_pc         <= '0;
            bus.upd_taken      <= 1'b0;
            bus.upd_target     <= '0;
        end else begin
            bus.redirect_valid <= mispred;
            bus.upd_valid      <= finish;
            if (finish) begin
                bus.upd_pc     <= fin.pc;
                bus.upd_taken  <= fin.taken;
                bus.upd_target <= fin.target;
            end
            // Not-taken fall-through skips the delay slot.
            if (mispred) bus.redirect_pc <= fin.taken ? fin.target : fin.pc + 32'd8;
            case (state)
                RUN:     if (mispred) state <= FLUSH;
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef BRANCH_RESOLVER_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_branch_cnt  <= '0;
            perf_mispred_cnt <= '0;
        end else begin
            if (bus.upd_valid)      perf_branch_cnt  <= perf_branch_cnt + 32'd1;
            if (bus.redirect_valid) perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
        end
    end
`endif

endmodule
